// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared encodings for the RISC core control interface:
//               next-PC select, branch condition codes and the fetch
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

   // Next-PC source selected by the decoder
   typedef enum logic [1:0] {
      PC_SEQ  = 2'b00,
      PC_JUMP = 2'b01,
      PC_JR   = 2'b10,
      PC_RSVD = 2'b11
   } pc_sel_e;

   // Branch condition codes; anything above BR_NS is undefined
   typedef enum logic [3:0] {
      BR_ALWAYS = 4'b0000,
      BR_S      = 4'b0001,
      BR_Z      = 4'b0010,
      BR_NZ     = 4'b0011,
      BR_C      = 4'b0100,
      BR_NC     = 4'b0101,
      BR_V      = 4'b0110,
      BR_NV     = 4'b0111,
      BR_NS     = 4'b1000
   } br_type_e;

   // Sequencer state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'b00;
   localparam state_t ST_FETCH = 2'b01;
   localparam state_t ST_ISSUE = 2'b10;
   localparam state_t ST_EXEC  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond
// Description : Combinational branch condition evaluator. Reports whether
//               the condition holds and whether the code is undefined.
//               Undefined codes are never taken.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond
   import risc_pkg::*;
(
   input  logic [3:0] br_type,
   input  logic       flag_z,
   input  logic       flag_s,
   input  logic       flag_c,
   input  logic       flag_v,
   output logic       taken,
   output logic       undef
);

   // Decode the condition code against the ALU flags
   always_comb begin
      taken = 1'b0;
      undef = 1'b0;
      case (br_type)
         BR_ALWAYS: taken = 1'b1;
         BR_S:      taken = flag_s;
         BR_Z:      taken = flag_z;
         BR_NZ:     taken = ~flag_z;
         BR_C:      taken = flag_c;
         BR_NC:     taken = ~flag_c;
         BR_V:      taken = flag_v;
         BR_NV:     taken = ~flag_v;
         BR_NS:     taken = ~flag_s;
         default:   undef = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter, instruction fetch over a req/ack memory
//               handshake, single-cycle issue to the decoder, and next-PC
//               selection once execute completes.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
   import risc_pkg::*;
#(
   parameter int               ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              exec_done,
   input  logic [1:0]        pc_sel,
   input  logic              br_en,
   input  logic [3:0]        br_type,
   input  logic              flag_z,
   input  logic              flag_s,
   input  logic              flag_c,
   input  logic              flag_v,
   input  logic [ADDR_W-1:0] rs_value,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link_addr,
   output logic [31:0]       retired,
   output logic              err_pulse
);

   state_t            r_state;
   logic              r_armed;
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_instr;
   logic [31:0]       r_retired;
   logic              r_err;

   logic [ADDR_W-1:0] w_pc_plus4;
   logic [ADDR_W-1:0] w_br_off;
   logic [ADDR_W-1:0] w_jump_tgt;
   logic [ADDR_W-1:0] w_next_pc;
   logic              w_err;
   logic              w_taken;
   logic              w_undef;

   assign w_pc_plus4 = r_pc + ADDR_W'(4);
   // Word offset: sign-extended 16-bit immediate scaled by 4
   assign w_br_off   = {{(ADDR_W-18){r_instr[15]}}, r_instr[15:0], 2'b00};

   // Region-relative jump keeps the upper bits of pc+4 above bit 27
   generate
      if (ADDR_W > 28) begin : g_jump_wide
         assign w_jump_tgt = {w_pc_plus4[ADDR_W-1:28], r_instr[25:0], 2'b00};
      end else begin : g_jump_narrow
         logic [27:0] w_jump_full;
         assign w_jump_full = {r_instr[25:0], 2'b00};
         assign w_jump_tgt  = w_jump_full[ADDR_W-1:0];
      end
   endgenerate

   branch_cond u_branch_cond (
      .br_type (br_type),
      .flag_z  (flag_z),
      .flag_s  (flag_s),
      .flag_c  (flag_c),
      .flag_v  (flag_v),
      .taken   (w_taken),
      .undef   (w_undef)
   );

   // Next-PC selection and error detection for the completing instruction
   always_comb begin
      w_next_pc = w_pc_plus4;
      w_err     = 1'b0;
      case (pc_sel)
         PC_SEQ: begin
            if (br_en) begin
               if (w_taken) begin
                  w_next_pc = w_pc_plus4 + w_br_off;
               end
               w_err = w_undef;
            end
         end
         PC_JUMP: w_next_pc = w_jump_tgt;
         PC_JR: begin
            w_next_pc = {rs_value[ADDR_W-1:2], 2'b00};
            w_err     = |rs_value[1:0];
         end
         default: w_err = 1'b1;
      endcase
   end

   // Sequencer FSM plus PC, instruction latch, retire counter and error flag.
   // r_armed holds IDLE for one full cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_armed   <= 1'b0;
         r_pc      <= RESET_PC;
         r_instr   <= '0;
         r_retired <= '0;
         r_err     <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_armed <= 1'b1;
               if (r_armed) begin
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  r_instr <= imem_rdata;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: r_state <= ST_EXEC;
            ST_EXEC: begin
               if (exec_done) begin
                  r_pc      <= w_next_pc;
                  r_retired <= r_retired + 32'd1;
                  r_err     <= w_err;
                  r_state   <= ST_FETCH;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign imem_req    = (r_state == ST_FETCH);
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_valid = (r_state == ST_ISSUE);
   assign pc          = r_pc;
   assign link_addr   = w_pc_plus4;
   assign retired     = r_retired;
   assign err_pulse   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        exec_done = 1'b0;
   logic [1:0]  pc_sel = 2'b00;
   logic        br_en = 1'b0;
   logic [3:0]  br_type = 4'h0;
   logic        flag_z = 1'b0;
   logic        flag_s = 1'b0;
   logic        flag_c = 1'b0;
   logic        flag_v = 1'b0;
   logic [31:0] rs_value = '0;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic [31:0] retired;
   logic        err_pulse;

   int n_vec = 0;
   int n_err = 0;

   pc_sequencer #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .exec_done   (exec_done),
      .pc_sel      (pc_sel),
      .br_en       (br_en),
      .br_type     (br_type),
      .flag_z      (flag_z),
      .flag_s      (flag_s),
      .flag_c      (flag_c),
      .flag_v      (flag_v),
      .rs_value    (rs_value),
      .pc          (pc),
      .link_addr   (link_addr),
      .retired     (retired),
      .err_pulse   (err_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One instruction starting in a FETCH cycle: zero-wait ack, issue,
   // execute completes on the first EXEC cycle. Ends in the next FETCH cycle.
   task automatic run_instr(input string tag, input logic [31:0] rdata,
                            input logic [1:0] sel, input logic be, input logic [3:0] bt,
                            input logic z, input logic [31:0] rs,
                            input logic [31:0] exp_pc, input logic exp_err,
                            input logic [31:0] exp_ret);
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      step();
      imem_ack   = 1'b0;
      chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, ".instr"}, instr, rdata);
      step();
      chk({tag, ".valid_drop"}, {31'd0, instr_valid}, 32'd0);
      exec_done = 1'b1;
      pc_sel    = sel;
      br_en     = be;
      br_type   = bt;
      flag_z    = z;
      rs_value  = rs;
      step();
      exec_done = 1'b0;
      pc_sel    = 2'b00;
      br_en     = 1'b0;
      br_type   = 4'h0;
      chk({tag, ".pc"}, pc, exp_pc);
      chk({tag, ".addr"}, imem_addr, exp_pc);
      chk({tag, ".req"}, {31'd0, imem_req}, 32'd1);
      chk({tag, ".err"}, {31'd0, err_pulse}, {31'd0, exp_err});
      chk({tag, ".retired"}, retired, exp_ret);
   endtask

   initial begin
      // Reset values
      #12;
      chk("rst.pc", pc, 32'h100);
      chk("rst.link", link_addr, 32'h104);
      chk("rst.instr", instr, 32'h0);
      chk("rst.retired", retired, 32'h0);
      chk("rst.req", {31'd0, imem_req}, 32'd0);
      chk("rst.valid", {31'd0, instr_valid}, 32'd0);
      chk("rst.err", {31'd0, err_pulse}, 32'd0);

      // Release between edges: IDLE for one full cycle, FETCH on 2nd edge
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rel.edge1_req", {31'd0, imem_req}, 32'd0);
      step();
      chk("rel.edge2_req", {31'd0, imem_req}, 32'd1);
      chk("rel.addr", imem_addr, 32'h100);

      // Sequential pair, 3 cycles each
      run_instr("seq1", 32'h1234_5678, 2'b00, 1'b0, 4'h0, 1'b0, 32'h0, 32'h104, 1'b0, 32'd1);
      run_instr("seq2", 32'h0000_0000, 2'b00, 1'b0, 4'h0, 1'b0, 32'h0, 32'h108, 1'b0, 32'd2);

      // Conditional branch at 0x200, offset -2 words, on Z
      run_instr("jr200a", 32'h0, 2'b10, 1'b0, 4'h0, 1'b0, 32'h200, 32'h200, 1'b0, 32'd3);
      run_instr("bz_t", 32'h0000_FFFE, 2'b00, 1'b1, 4'h2, 1'b1, 32'h0, 32'h1FC, 1'b0, 32'd4);
      run_instr("jr200b", 32'h0, 2'b10, 1'b0, 4'h0, 1'b0, 32'h200, 32'h200, 1'b0, 32'd5);
      run_instr("bz_nt", 32'h0000_FFFE, 2'b00, 1'b1, 4'h2, 1'b0, 32'h0, 32'h204, 1'b0, 32'd6);

      // Region jump from 0x1000_0000
      run_instr("jr1000", 32'h0, 2'b10, 1'b0, 4'h0, 1'b0, 32'h1000_0000, 32'h1000_0000, 1'b0, 32'd7);
      run_instr("jump", 32'h0000_0040, 2'b01, 1'b0, 4'h0, 1'b0, 32'h0, 32'h1000_0100, 1'b0, 32'd8);

      // Misaligned jr: aligned target plus error, error lasts one cycle
      run_instr("jr_mis", 32'h0, 2'b10, 1'b0, 4'h0, 1'b0, 32'h303, 32'h300, 1'b1, 32'd9);
      step();
      chk("jr_mis.err_drop", {31'd0, err_pulse}, 32'd0);
      chk("jr_mis.req_hold", {31'd0, imem_req}, 32'd1);
      chk("jr_mis.addr_hold", imem_addr, 32'h300);

      // Reserved pc_sel and undefined br_type
      run_instr("rsvd", 32'h0, 2'b11, 1'b0, 4'h0, 1'b0, 32'h0, 32'h304, 1'b1, 32'd10);
      run_instr("bt_undef", 32'h0, 2'b00, 1'b1, 4'hF, 1'b1, 32'h0, 32'h308, 1'b1, 32'd11);
      // Undefined br_type without br_en is ignored
      run_instr("bt_ign", 32'h0, 2'b00, 1'b0, 4'hF, 1'b1, 32'h0, 32'h30C, 1'b0, 32'd12);
      // Branch always, forward 3 words: 0x310 + 0xC
      run_instr("b_always", 32'h0000_0003, 2'b00, 1'b1, 4'h0, 1'b0, 32'h0, 32'h31C, 1'b0, 32'd13);
      chk("link", link_addr, 32'h320);

      // Stalled fetch; exec_done outside EXEC must not move the PC
      exec_done = 1'b1;
      pc_sel    = 2'b01;
      step();
      exec_done = 1'b0;
      pc_sel    = 2'b00;
      chk("stall.pc", pc, 32'h31C);
      chk("stall.ret", retired, 32'd13);
      step();
      step();
      chk("stall.req", {31'd0, imem_req}, 32'd1);

      // Asynchronous reset mid-fetch
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid.req", {31'd0, imem_req}, 32'd0);
      chk("mid.pc", pc, 32'h100);
      chk("mid.ret", retired, 32'd0);
      chk("mid.instr", instr, 32'h0);
      @(negedge clk);
      rst_n      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      step();
      imem_ack = 1'b0;
      chk("mid.restart_req", {31'd0, imem_req}, 32'd1);
      chk("mid.restart_addr", imem_addr, 32'h100);
      step();
      chk("mid.late_ack_valid", {31'd0, instr_valid}, 32'd0);
      chk("mid.late_ack_instr", instr, 32'h0);
      chk("mid.still_fetch", {31'd0, imem_req}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
